// File: rtl/matrix_feeder.sv
// matrix_feeder: stores operand matrices A and B and drives the diagonally skewed wavefront into the systolic array.
// Latency: DONE pulses 3*LENGTH+1 cycles after the START edge; all outputs are registered one cycle behind the FSM.
// No backpressure: START is taken only in IDLE (and not while DONE shows), row writes only in IDLE, all else dropped.
module matrix_feeder #(
  parameter  int WIDTH  = 8,
  parameter  int LENGTH = 3,
  localparam int AW     = (LENGTH > 1) ? $clog2(LENGTH) : 1,
  localparam int CW     = $clog2(3 * LENGTH)
) (
  input  logic                    CLK,
  input  logic                    ASYNC_RST,
  input  logic                    SYNC_RST,
  input  logic                    WR_EN,
  input  logic                    WR_SEL,
  input  logic [AW-1:0]           WR_ADDR,
  input  logic [WIDTH*LENGTH-1:0] WR_DATA,
  input  logic                    START,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    MMU_CLR,
  output logic                    MMU_EN,
  output logic [WIDTH-1:0]        Inputs  [0:LENGTH-1],
  output logic [WIDTH-1:0]        Weights [0:LENGTH-1]
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_FINISH
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a [0:LENGTH-1][0:LENGTH-1];
  logic [WIDTH-1:0] r_b [0:LENGTH-1][0:LENGTH-1];
  logic [WIDTH-1:0] w_in [0:LENGTH-1];
  logic [WIDTH-1:0] w_wt [0:LENGTH-1];
  logic             w_wr_ok;

  // Rows land only while idle and only for in-range row indices.
  assign w_wr_ok = WR_EN && (r_state == ST_IDLE) && (int'(WR_ADDR) < LENGTH);

  // Operand storage: zeroed by either reset, otherwise written one row at a time.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      for (int r = 0; r < LENGTH; r++) begin
        for (int c = 0; c < LENGTH; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else if (SYNC_RST) begin
      for (int r = 0; r < LENGTH; r++) begin
        for (int c = 0; c < LENGTH; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      for (int c = 0; c < LENGTH; c++) begin
        if (WR_SEL) begin
          r_b[WR_ADDR][c] <= WR_DATA[c*WIDTH +: WIDTH];
        end else begin
          r_a[WR_ADDR][c] <= WR_DATA[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Wavefront for the current stream step k: row r carries A[r][k-r], column r carries B[k-r][r].
  always_comb begin
    for (int r = 0; r < LENGTH; r++) begin
      w_in[r] = '0;
      w_wt[r] = '0;
    end
    if (r_state == ST_STREAM) begin
      for (int r = 0; r < LENGTH; r++) begin
        for (int c = 0; c < LENGTH; c++) begin
          if (r + c == int'(r_cnt)) begin
            w_in[r] = r_a[r][c];
            w_wt[r] = r_b[c][r];
          end
        end
      end
    end
  end

  // Pass sequencer; outputs are registered decodes of the state, so they trail it by one cycle.
  always_ff @(posedge CLK or negedge ASYNC_RST) begin
    if (!ASYNC_RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      MMU_CLR <= 1'b0;
      MMU_EN  <= 1'b0;
      for (int r = 0; r < LENGTH; r++) begin
        Inputs[r]  <= '0;
        Weights[r] <= '0;
      end
    end else if (SYNC_RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      MMU_CLR <= 1'b0;
      MMU_EN  <= 1'b0;
      for (int r = 0; r < LENGTH; r++) begin
        Inputs[r]  <= '0;
        Weights[r] <= '0;
      end
    end else begin
      MMU_CLR <= (r_state == ST_CLEAR);
      MMU_EN  <= (r_state == ST_STREAM) || (r_state == ST_DRAIN);
      DONE    <= (r_state == ST_FINISH);
      for (int r = 0; r < LENGTH; r++) begin
        Inputs[r]  <= w_in[r];
        Weights[r] <= w_wt[r];
      end
      case (r_state)
        ST_IDLE: begin
          // DONE high is the externally visible FINISH cycle, so START is not taken there.
          if (START && !DONE) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
            BUSY    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          r_state <= ST_STREAM;
          r_cnt   <= '0;
        end
        ST_STREAM: begin
          if (r_cnt == CW'(2 * LENGTH - 2)) begin
            r_state <= (LENGTH > 1) ? ST_DRAIN : ST_FINISH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (r_cnt == CW'(LENGTH - 2)) begin
            r_state <= ST_FINISH;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          BUSY    <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Bench for matrix_feeder: directed passes plus random matrices, checked against a cycle-level
// expectation of the streams and against A*B accumulated by a behavioural systolic array fed by the DUT.
module tb_matrix_feeder;
  localparam int W  = 8;
  localparam int L  = 3;
  localparam int AW = 2;

  logic           CLK = 1'b0;
  logic           ASYNC_RST, SYNC_RST, WR_EN, WR_SEL, START;
  logic [AW-1:0]  WR_ADDR;
  logic [W*L-1:0] WR_DATA;
  logic           BUSY, DONE, MMU_CLR, MMU_EN;
  logic [W-1:0]   Inputs  [0:L-1];
  logic [W-1:0]   Weights [0:L-1];

  int n_checks = 0;
  int n_err    = 0;
  int ma [L][L];
  int mb [L][L];
  int acc [L][L];
  int ah  [L][L];
  int bv  [L][L];
  int gold [L][L] = '{'{115, 56, 84}, '{125, 60, 89}, '{148, 64, 84}};

  always #5 CLK = ~CLK;

  matrix_feeder #(.WIDTH(W), .LENGTH(L)) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
    .WR_EN(WR_EN), .WR_SEL(WR_SEL), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .START(START), .BUSY(BUSY), .DONE(DONE), .MMU_CLR(MMU_CLR), .MMU_EN(MMU_EN),
    .Inputs(Inputs), .Weights(Weights)
  );

  function automatic int a_at(int i, int j);
    if (j == 0) return int'(Inputs[i]);
    return ah[i][j-1];
  endfunction

  function automatic int b_at(int i, int j);
    if (i == 0) return int'(Weights[j]);
    return bv[i-1][j];
  endfunction

  // Output-stationary array: A flows right, B flows down, each cell accumulates its products.
  always @(posedge CLK) begin
    if (MMU_CLR === 1'b1) begin
      for (int i = 0; i < L; i++) for (int j = 0; j < L; j++) begin
        acc[i][j] <= 0; ah[i][j] <= 0; bv[i][j] <= 0;
      end
    end else if (MMU_EN === 1'b1) begin
      for (int i = 0; i < L; i++) for (int j = 0; j < L; j++) begin
        acc[i][j] <= acc[i][j] + a_at(i, j) * b_at(i, j);
        ah[i][j]  <= a_at(i, j);
        bv[i][j]  <= b_at(i, j);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_out(bit wt);
    logic [31:0] v = '0;
    for (int r = 0; r < L; r++) v[r*W +: W] = wt ? Weights[r] : Inputs[r];
    return v;
  endfunction

  // Cycle t after the START edge shows stream step k = t-3.
  function automatic logic [31:0] exp_stream(int t, bit wt);
    logic [31:0] v = '0;
    int k = t - 3;
    if (k >= 0 && k <= 2*L-2) begin
      for (int r = 0; r < L; r++) begin
        if (k - r >= 0 && k - r < L) v[r*W +: W] = wt ? W'(mb[k-r][r]) : W'(ma[r][k-r]);
      end
    end
    return v;
  endfunction

  function automatic int prod(int i, int j);
    int s = 0;
    for (int k = 0; k < L; k++) s += ma[i][k] * mb[k][j];
    return s;
  endfunction

  function automatic logic [W*L-1:0] row3(int e0, int e1, int e2);
    return {W'(e2), W'(e1), W'(e0)};
  endfunction

  task automatic drive_idle();
    WR_EN = 1'b0; WR_SEL = 1'b0; WR_ADDR = '0; WR_DATA = '0; START = 1'b0; SYNC_RST = 1'b0;
  endtask

  task automatic zero_model();
    for (int i = 0; i < L; i++) for (int j = 0; j < L; j++) begin ma[i][j] = 0; mb[i][j] = 0; end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
    chk({tag, "_clr"}, MMU_CLR, 0);
    chk({tag, "_en"}, MMU_EN, 0);
    chk({tag, "_inputs"}, pack_out(0), 0);
    chk({tag, "_weights"}, pack_out(1), 0);
  endtask

  // Write one row from IDLE; the model keeps only in-range rows.
  task automatic wr_row(input bit sel, input int addr, input logic [W*L-1:0] data);
    WR_EN = 1'b1; WR_SEL = sel; WR_ADDR = AW'(addr); WR_DATA = data;
    if (addr < L) begin
      for (int c = 0; c < L; c++) begin
        if (sel) mb[addr][c] = int'(data[c*W +: W]);
        else     ma[addr][c] = int'(data[c*W +: W]);
      end
    end
    @(negedge CLK);
    drive_idle();
  endtask

  // One full pass from a negedge in IDLE; optional dropped write / START at cycle wr_t / start_t.
  task automatic run_pass(input int wr_t, input int start_t, input bit same_wr,
                          input logic [W*L-1:0] same_row, input bit golden);
    START = 1'b1;
    if (same_wr) begin
      WR_EN = 1'b1; WR_SEL = 1'b0; WR_ADDR = 2'd2; WR_DATA = same_row;
      for (int c = 0; c < L; c++) ma[2][c] = int'(same_row[c*W +: W]);
    end
    for (int t = 1; t <= 3*L+3; t++) begin
      @(negedge CLK);
      drive_idle();
      chk($sformatf("clr@%0d", t), MMU_CLR, (t == 2));
      chk($sformatf("en@%0d", t), MMU_EN, (t >= 3 && t <= 3*L));
      chk($sformatf("done@%0d", t), DONE, (t == 3*L+1));
      chk($sformatf("busy@%0d", t), BUSY, (t >= 1 && t <= 3*L));
      chk($sformatf("inputs@%0d", t), pack_out(0), exp_stream(t, 0));
      chk($sformatf("weights@%0d", t), pack_out(1), exp_stream(t, 1));
      if (t == 3*L+1) begin
        for (int i = 0; i < L; i++) for (int j = 0; j < L; j++) begin
          chk($sformatf("result[%0d][%0d]", i, j), acc[i][j], prod(i, j));
          if (golden) chk($sformatf("golden[%0d][%0d]", i, j), acc[i][j], gold[i][j]);
        end
      end
      if (t == wr_t) begin
        WR_EN = 1'b1; WR_SEL = 1'b0; WR_ADDR = 2'd0; WR_DATA = row3(1, 1, 1);
      end
      if (t == start_t) START = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    drive_idle();
    zero_model();
    ASYNC_RST = 1'b0;
    repeat (2) @(negedge CLK);
    chk_all_zero("reset");
    ASYNC_RST = 1'b1;
    @(negedge CLK);
    chk("post_reset_busy", BUSY, 0);

    // Golden matrices
    wr_row(0, 0, row3(4, 3, 7));  wr_row(0, 1, row3(4, 4, 7));  wr_row(0, 2, row3(6, 8, 2));
    wr_row(1, 0, row3(9, 4, 5));  wr_row(1, 1, row3(10, 4, 5)); wr_row(1, 2, row3(7, 4, 7));
    run_pass(0, 0, 1'b0, '0, 1'b1);

    // Write during STREAM and START during DRAIN are both dropped; storage must be unchanged.
    run_pass(4, 8, 1'b0, '0, 1'b1);
    // START while DONE shows is not accepted.
    run_pass(0, 3*L+1, 1'b0, '0, 1'b1);

    // Out-of-range row index is ignored.
    wr_row(0, 3, row3(9, 9, 9));
    wr_row(1, 3, row3(9, 9, 9));
    run_pass(0, 0, 1'b0, '0, 1'b1);

    // Random matrices
    repeat (4) begin
      for (int r = 0; r < L; r++) begin
        wr_row(0, r, W*L'($urandom));
        wr_row(1, r, W*L'($urandom));
      end
      run_pass(0, 0, 1'b0, '0, 1'b0);
    end

    // Row write in the same cycle as START is used by that pass.
    run_pass(0, 0, 1'b1, row3(1, 2, 3), 1'b0);

    // SYNC_RST at stream step 1 aborts the pass and clears storage.
    START = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      @(negedge CLK);
      drive_idle();
      if (t == 4) begin
        chk("abort_pre_en", MMU_EN, 1);
        SYNC_RST = 1'b1;
      end
      if (t == 5) chk_all_zero("abort");
      if (t >= 5) chk($sformatf("abort_done@%0d", t), DONE, 0);
    end
    zero_model();
    run_pass(0, 0, 1'b0, '0, 1'b0);

    // ASYNC_RST mid-cycle clears outputs immediately.
    wr_row(0, 0, row3(5, 6, 7));
    wr_row(1, 0, row3(2, 3, 4));
    START = 1'b1;
    @(negedge CLK);
    drive_idle();
    repeat (4) @(posedge CLK);
    #1;
    chk("arst_pre_en", MMU_EN, 1);
    #1;
    ASYNC_RST = 1'b0;
    #1;
    chk_all_zero("arst");
    @(negedge CLK);
    ASYNC_RST = 1'b1;
    zero_model();
    @(negedge CLK);
    chk("arst_after_busy", BUSY, 0);
    run_pass(0, 0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
